// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - decode stage types and fetch/execute handshake interface
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_t;

  typedef enum logic {
    SRC_A_RS1 = 1'b0,
    SRC_A_PC  = 1'b1
  } a_sel_t;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } b_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       regwen;
    imm_sel_t   imm_sel;
    a_sel_t     a_sel;
    b_sel_t     b_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } control_signals_t;

  // Everything the stage captures per instruction besides the pc
  typedef struct packed {
    control_signals_t ctrl;
    logic [31:0]      imm;
    logic             mem_rd;
    logic             mem_wr;
    logic [2:0]       funct3;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             illegal;
    logic             md_en;
  } dec_t;

endpackage

interface decode_stage_if #(
  parameter int PC_W = 32
);
  import decode_stage_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  control_signals_t out_ctrl;
  logic [31:0]      out_imm;
  logic             out_mem_rd;
  logic             out_mem_wr;
  logic [2:0]       out_funct3;
  logic             out_branch;
  logic             out_jal;
  logic             out_jalr;
  logic             out_illegal;
  logic             out_md_en;

  // Surrounding pipeline: fetch drives the input side, execute drives out_ready
  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_imm, out_mem_rd, out_mem_wr,
           out_funct3, out_branch, out_jal, out_jalr, out_illegal, out_md_en
  );

  // The decode stage itself
  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_imm, out_mem_rd, out_mem_wr,
           out_funct3, out_branch, out_jal, out_jalr, out_illegal, out_md_en
  );

endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with skid buffer; DECODE_RV32M_EN adds RV32M decode
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  decode_stage_if.slave          bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  state_t          state, state_next;
  logic            in_ready_q;
  logic [PC_W-1:0] out_pc_q, skid_pc_q;
  dec_t            out_dec_q, skid_dec_q, dec;
  logic            accept, emit, out_valid;
  logic            load_out, load_out_from_skid, load_skid;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational decode of the presented instruction; FENCE/SYSTEM are not decoded and trap as illegal
  always_comb begin
    dec          = '0;
    illegal      = 1'b0;
    dec.ctrl.rs1 = instr[19:15];
    dec.ctrl.rs2 = instr[24:20];
    dec.ctrl.rd  = instr[11:7];
    dec.funct3   = funct3;
    case (opcode)
      OPC_LUI: begin
        dec.ctrl.imm_sel = IMM_U;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.ctrl.alu_op  = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec.ctrl.imm_sel = IMM_U;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.a_sel   = SRC_A_PC;
        dec.ctrl.b_sel   = SRC_B_IMM;
      end
      OPC_JAL: begin
        dec.ctrl.imm_sel = IMM_J;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.a_sel   = SRC_A_PC;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.jal          = 1'b1;
      end
      OPC_JALR: begin
        dec.ctrl.imm_sel = IMM_I;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.jalr         = 1'b1;
        illegal          = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.ctrl.imm_sel = IMM_B;
        dec.ctrl.a_sel   = SRC_A_PC;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.branch       = 1'b1;
        illegal          = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.ctrl.imm_sel = IMM_I;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.mem_rd       = 1'b1;
        illegal          = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.ctrl.imm_sel = IMM_S;
        dec.ctrl.b_sel   = SRC_B_IMM;
        dec.mem_wr       = 1'b1;
        illegal          = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec.ctrl.imm_sel = IMM_I;
        dec.ctrl.regwen  = 1'b1;
        dec.ctrl.b_sel   = SRC_B_IMM;
        // Only shift-right uses funct7 to pick arithmetic; ADDI never becomes SUB
        dec.ctrl.alu_op  = alu_from_funct3(funct3, (funct3 == 3'b101) && (funct7 == 7'b0100000));
        if (funct3 == 3'b001)
          illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP: begin
        dec.ctrl.regwen = 1'b1;
        dec.ctrl.alu_op = alu_from_funct3(funct3, funct7 == 7'b0100000);
        if (funct7 == 7'b0100000)
          illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef DECODE_RV32M_EN
        else if (funct7 == 7'b0000001) begin
          dec.md_en       = 1'b1;
          dec.ctrl.alu_op = ALU_ADD;
        end
`endif
        else
          illegal = (funct7 != 7'b0000000);
      end
      default: illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      illegal = 1'b1;
    case (dec.ctrl.imm_sel)
      IMM_I:   dec.imm = imm_i;
      IMM_S:   dec.imm = imm_s;
      IMM_B:   dec.imm = imm_b;
      IMM_U:   dec.imm = imm_u;
      IMM_J:   dec.imm = imm_j;
      default: dec.imm = 32'd0;
    endcase
    // Illegal instructions travel on but must not write state or redirect flow
    if (illegal) begin
      dec.illegal     = 1'b1;
      dec.ctrl.regwen = 1'b0;
      dec.mem_rd      = 1'b0;
      dec.mem_wr      = 1'b0;
      dec.branch      = 1'b0;
      dec.jal         = 1'b0;
      dec.jalr        = 1'b0;
      dec.md_en       = 1'b0;
    end
  end

  assign out_valid = (state != EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign emit      = out_valid && bus.out_ready;

  // State register plus registered in_ready, which drops only while the skid holds an instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != SKID);
    end
  end

  // Next state and load strobes; flush outranks any accept or emit in the same cycle
  always_comb begin
    state_next         = state;
    load_out           = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = FULL;
            load_out   = 1'b1;
          end
        end
        FULL: begin
          if (emit && accept) begin
            load_out = 1'b1;
          end else if (emit) begin
            state_next = EMPTY;
          end else if (accept) begin
            state_next = SKID;
            load_skid  = 1'b1;
          end
        end
        SKID: begin
          if (emit) begin
            state_next         = FULL;
            load_out_from_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output and skid payload registers; they only change on a load so a stalled output holds steady
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_pc_q   <= '0;
      out_dec_q  <= '0;
      skid_pc_q  <= '0;
      skid_dec_q <= '0;
    end else begin
      if (load_out) begin
        out_pc_q  <= bus.in_pc;
        out_dec_q <= dec;
      end else if (load_out_from_skid) begin
        out_pc_q  <= skid_pc_q;
        out_dec_q <= skid_dec_q;
      end
      if (load_skid) begin
        skid_pc_q  <= bus.in_pc;
        skid_dec_q <= dec;
      end
    end
  end

  // Saturating count of cycles where execute holds off a valid output
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !bus.out_ready && (stall_cnt != STALL_MAX))
      stall_cnt <= stall_cnt + STALL_ONE;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_ctrl    = out_dec_q.ctrl;
  assign bus.out_imm     = out_dec_q.imm;
  assign bus.out_mem_rd  = out_dec_q.mem_rd;
  assign bus.out_mem_wr  = out_dec_q.mem_wr;
  assign bus.out_funct3  = out_dec_q.funct3;
  assign bus.out_branch  = out_dec_q.branch;
  assign bus.out_jal     = out_dec_q.jal;
  assign bus.out_jalr    = out_dec_q.jalr;
  assign bus.out_illegal = out_dec_q.illegal;
  assign bus.out_md_en   = out_dec_q.md_en;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] stall_cnt;
  int         n_cmp = 0;
  int         n_err = 0;

  decode_stage_if #(.PC_W(32)) bus ();

  decode_stage #(.PC_W(32), .STALL_CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = ins;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_imm", bus.out_imm, 32'd0);
    chk("rst_out_ctrl", 32'(bus.out_ctrl), 32'd0);

    // ADDI x1,x0,5
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h00500093);
    tick();
    chk("addi_valid", 32'(bus.out_valid), 32'd1);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_imm", bus.out_imm, 32'd5);
    chk("addi_rd", 32'(bus.out_ctrl.rd), 32'd1);
    chk("addi_regwen", 32'(bus.out_ctrl.regwen), 32'd1);
    chk("addi_b_sel", 32'(bus.out_ctrl.b_sel), 32'(SRC_B_IMM));
    chk("addi_alu", 32'(bus.out_ctrl.alu_op), 32'(ALU_ADD));
    chk("addi_imm_sel", 32'(bus.out_ctrl.imm_sel), 32'(IMM_I));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("addi_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: A, B accepted, C held off by the skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h00500093);
    tick();
    chk("bp_a_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_a_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h204, 32'h402081B3);
    tick();
    chk("bp_skid_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_pc1", bus.out_pc, 32'h200);
    chk("bp_stall1", 32'(stall_cnt), 32'd1);
    drive(1'b1, 32'h208, 32'h00C00113);
    tick();
    chk("bp_hold_pc2", bus.out_pc, 32'h200);
    chk("bp_hold_imm", bus.out_imm, 32'd5);
    chk("bp_c_blocked", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_stall3", 32'(stall_cnt), 32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_b_pc", bus.out_pc, 32'h204);
    chk("bp_b_alu", 32'(bus.out_ctrl.alu_op), 32'(ALU_SUB));
    chk("bp_b_rd", 32'(bus.out_ctrl.rd), 32'd3);
    chk("bp_b_imm_sel", 32'(bus.out_ctrl.imm_sel), 32'(IMM_NONE));
    chk("bp_b_imm", bus.out_imm, 32'd0);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_c_pc", bus.out_pc, 32'h208);
    chk("bp_c_imm", bus.out_imm, 32'd12);
    chk("bp_c_rd", 32'(bus.out_ctrl.rd), 32'd2);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_stall_total", 32'(stall_cnt), 32'd3);

    // Back-to-back decode stream with out_ready held high
    drive(1'b1, 32'h300, 32'h0020A423);
    tick();
    chk("sw_mem_wr", 32'(bus.out_mem_wr), 32'd1);
    chk("sw_imm", bus.out_imm, 32'd8);
    chk("sw_imm_sel", 32'(bus.out_ctrl.imm_sel), 32'(IMM_S));
    chk("sw_regwen", 32'(bus.out_ctrl.regwen), 32'd0);
    chk("sw_funct3", 32'(bus.out_funct3), 32'd2);
    drive(1'b1, 32'h304, 32'hFE000EE3);
    tick();
    chk("beq_branch", 32'(bus.out_branch), 32'd1);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("beq_a_sel", 32'(bus.out_ctrl.a_sel), 32'(SRC_A_PC));
    chk("beq_pc", bus.out_pc, 32'h304);
    drive(1'b1, 32'h308, 32'hFFFFFFFF);
    tick();
    chk("ones_illegal", 32'(bus.out_illegal), 32'd1);
    chk("ones_regwen", 32'(bus.out_ctrl.regwen), 32'd0);
    chk("ones_mem_rd", 32'(bus.out_mem_rd), 32'd0);
    drive(1'b1, 32'h30C, 32'h00003083);
    tick();
    chk("ld011_illegal", 32'(bus.out_illegal), 32'd1);
    chk("ld011_regwen", 32'(bus.out_ctrl.regwen), 32'd0);
    chk("ld011_mem_rd", 32'(bus.out_mem_rd), 32'd0);
    drive(1'b1, 32'h310, 32'h0040A103);
    tick();
    chk("lw_mem_rd", 32'(bus.out_mem_rd), 32'd1);
    chk("lw_regwen", 32'(bus.out_ctrl.regwen), 32'd1);
    chk("lw_imm", bus.out_imm, 32'd4);
    chk("lw_illegal", 32'(bus.out_illegal), 32'd0);
    drive(1'b1, 32'h314, 32'h008000EF);
    tick();
    chk("jal_flag", 32'(bus.out_jal), 32'd1);
    chk("jal_imm", bus.out_imm, 32'd8);
    chk("jal_imm_sel", 32'(bus.out_ctrl.imm_sel), 32'(IMM_J));
    drive(1'b1, 32'h318, 32'h123450B7);
    tick();
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_alu", 32'(bus.out_ctrl.alu_op), 32'(ALU_PASS_B));
    drive(1'b1, 32'h31C, 32'h40109093);
    tick();
    chk("slli_bad_illegal", 32'(bus.out_illegal), 32'd1);
    drive(1'b1, 32'h320, 32'h4010D093);
    tick();
    chk("srai_illegal", 32'(bus.out_illegal), 32'd0);
    chk("srai_alu", 32'(bus.out_ctrl.alu_op), 32'(ALU_SRA));
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("stream_drained", 32'(bus.out_valid), 32'd0);

    // Flush while the skid is full and fetch still offers an instruction
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h00500093);
    tick();
    drive(1'b1, 32'h404, 32'h00C00113);
    tick();
    chk("fl_skid_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h408, 32'h0020A423);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fl_stall", 32'(stall_cnt), 32'd5);
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    tick();
    chk("fl_nothing_left", 32'(bus.out_valid), 32'd0);
    // An accept coinciding with flush is dropped
    drive(1'b1, 32'h500, 32'h00500093);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_accept_dropped", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 32'h504, 32'h00500093);
    tick();
    chk("fl_resume_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_resume_pc", bus.out_pc, 32'h504);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // MUL x3,x1,x2
    drive(1'b1, 32'h600, 32'h022081B3);
    tick();
`ifdef DECODE_RV32M_EN
    chk("mul_md_en", 32'(bus.out_md_en), 32'd1);
    chk("mul_illegal", 32'(bus.out_illegal), 32'd0);
    chk("mul_regwen", 32'(bus.out_ctrl.regwen), 32'd1);
`else
    chk("mul_md_en", 32'(bus.out_md_en), 32'd0);
    chk("mul_illegal", 32'(bus.out_illegal), 32'd1);
    chk("mul_regwen", 32'(bus.out_ctrl.regwen), 32'd0);
`endif
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Stall counter saturates at all-ones (4-bit instance)
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h700, 32'h00500093);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_reach", 32'(stall_cnt), 32'd15);
    tick();
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'd15);
    chk("sat_payload_pc", bus.out_pc, 32'h700);
    bus.out_ready = 1'b1;
    tick();
    chk("sat_drained", 32'(bus.out_valid), 32'd0);
    chk("sat_after", 32'(stall_cnt), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
